// File: rtl/sample_deser.sv
// sample_deser -- serial-to-parallel sample deserializer with a one-entry
// output register feeding the downstream FP encoder.
//
// Optional build macro: PARITY_CHECK_EN. When it is defined, each frame
// carries one trailing even-parity bit and the parity_err port is present.
// When it is undefined, frames are WIDTH cycles long and there is no
// parity_err port.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-high reset
//   ser_in       in   serial data, MSB first
//   ser_start    in   frame start; ser_in carries bit WIDTH-1 this cycle
//   out_ready    in   downstream takes the word when sample_valid && out_ready
//   sample       out  assembled two's-complement word [WIDTH-1:0]
//   sample_valid out  sample holds an unconsumed word
//   busy         out  a frame is being shifted in
//   overrun      out  one-cycle pulse when a completed frame is dropped
//   parity_err   out  one-cycle pulse on parity mismatch (PARITY_CHECK_EN only)
module sample_deser #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    // Counter holds the bit position captured on the next SHIFT cycle.
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
`ifdef PARITY_CHECK_EN
    // The whole data word is held in the shifter while the parity bit arrives.
    localparam int unsigned SW = WIDTH;
`else
    // Bit 0 is taken straight from ser_in on the completing edge.
    localparam int unsigned SW = WIDTH - 1;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   shreg;
`ifdef PARITY_CHECK_EN
    logic            par_phase;
`endif

    logic            frame_done;
    logic            frame_bad;
    logic [WIDTH-1:0] frame_word;
    logic            load_ok;

    // Frame completion decode; a restart on the final cycle wins over completion.
    always_comb begin
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        frame_word = '0;
        load_ok    = !sample_valid || out_ready;
`ifdef PARITY_CHECK_EN
        frame_word = shreg;
        frame_bad  = (^shreg) ^ ser_in;
        frame_done = (state == SHIFT) && !ser_start && par_phase;
`else
        frame_word = {shreg, ser_in};
        frame_done = (state == SHIFT) && !ser_start && (cnt == '0);
`endif
    end

    // FSM, shifter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_phase    <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif

            // Consume; a completing frame below may reload on the same edge.
            if (sample_valid && out_ready) begin
                sample_valid <= 1'b0;
            end

            if (frame_done) begin
                if (frame_bad) begin
`ifdef PARITY_CHECK_EN
                    parity_err <= 1'b1;
`endif
                end else if (load_ok) begin
                    sample       <= frame_word;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ser_start) begin
                        shreg <= {{(SW-1){1'b0}}, ser_in};
                        cnt   <= CW'(WIDTH - 2);
                        state <= SHIFT;
                        busy  <= 1'b1;
`ifdef PARITY_CHECK_EN
                        par_phase <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (ser_start) begin
                        // Abort the partial frame and restart at the MSB.
                        shreg <= {{(SW-1){1'b0}}, ser_in};
                        cnt   <= CW'(WIDTH - 2);
`ifdef PARITY_CHECK_EN
                        par_phase <= 1'b0;
`endif
                    end else begin
`ifdef PARITY_CHECK_EN
                        if (par_phase) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            par_phase <= 1'b0;
                        end else begin
                            shreg <= {shreg[SW-2:0], ser_in};
                            if (cnt == '0) begin
                                par_phase <= 1'b1;
                            end else begin
                                cnt <= cnt - CW'(1);
                            end
                        end
`else
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            shreg <= {shreg[SW-2:0], ser_in};
                            cnt   <= cnt - CW'(1);
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_deser.sv
// tb_sample_deser -- directed, table-driven bench for sample_deser (WIDTH=12).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_sample_deser;

    localparam int unsigned W = 12;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic         clk;
    logic         rst;
    logic         ser_in;
    logic         ser_start;
    logic         out_ready;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic         busy;
    logic         overrun;
`ifdef PARITY_CHECK_EN
    logic         parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sample_deser #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ser_in       (ser_in),
        .ser_start    (ser_start),
        .out_ready    (out_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic         rdy;
        logic [W-1:0] exp_sample;
        logic         exp_valid;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame; out_ready is only raised on the completing cycle.
    task automatic send_frame(input logic [W-1:0] w, input logic rdy, input logic pflip);
        logic pbit;
        pbit = (^w) ^ pflip;
        for (int i = 0; i < int'(FL); i++) begin
            ser_start = (i == 0);
            ser_in    = (i < int'(W)) ? w[W-1-i] : pbit;
            out_ready = (i == int'(FL) - 1) ? rdy : 1'b0;
            tick();
            if (i < int'(FL) - 1) begin
                check("busy_in_frame", 32'(busy), 32'd1);
                check("overrun_in_frame", 32'(overrun), 32'd0);
            end
        end
        ser_start = 1'b0;
        out_ready = 1'b0;
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    // First n bits of a frame only.
    task automatic send_partial(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_start = (i == 0);
            ser_in    = w[W-1-i];
            out_ready = 1'b0;
            tick();
            check("busy_partial", 32'(busy), 32'd1);
        end
        ser_start = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_consume", 32'(sample_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{word: 12'h801, rdy: 1'b0, exp_sample: 12'h801, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[1] = '{word: 12'h7FF, rdy: 1'b0, exp_sample: 12'h801, exp_valid: 1'b1, exp_ovr: 1'b1};
        tbl[2] = '{word: 12'h123, rdy: 1'b1, exp_sample: 12'h123, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[3] = '{word: 12'hFFF, rdy: 1'b1, exp_sample: 12'hFFF, exp_valid: 1'b1, exp_ovr: 1'b0};
        tbl[4] = '{word: 12'h000, rdy: 1'b0, exp_sample: 12'hFFF, exp_valid: 1'b1, exp_ovr: 1'b1};

        rst       = 1'b1;
        ser_in    = 1'b0;
        ser_start = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
`ifdef PARITY_CHECK_EN
        check("rst_parity_err", 32'(parity_err), 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Back-to-back frames straight out of reset.
        for (int k = 0; k < 5; k++) begin
            send_frame(tbl[k].word, tbl[k].rdy, 1'b0);
            check($sformatf("tbl%0d_sample", k), 32'(sample), 32'(tbl[k].exp_sample));
            check($sformatf("tbl%0d_valid", k), 32'(sample_valid), 32'(tbl[k].exp_valid));
            check($sformatf("tbl%0d_overrun", k), 32'(overrun), 32'(tbl[k].exp_ovr));
        end

        // Overrun is a single-cycle pulse; consume keeps the word on sample.
        consume();
        check("overrun_one_cycle", 32'(overrun), 32'd0);
        check("sample_held_after_consume", 32'(sample), 32'hFFF);

        // ser_in ignored in IDLE without ser_start.
        for (int i = 0; i < 4; i++) begin
            ser_in = 1'($urandom_range(0, 1));
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(sample_valid), 32'd0);
        end

        // Restart at bit 5 of 0xABC, then 0x010 is the only word delivered.
        send_partial(12'hABC, 6);
        check("abort_no_valid", 32'(sample_valid), 32'd0);
        send_frame(12'h010, 1'b0, 1'b0);
        check("abort_sample", 32'(sample), 32'h010);
        check("abort_valid", 32'(sample_valid), 32'd1);
        check("abort_overrun", 32'(overrun), 32'd0);
        consume();

        // Asynchronous reset mid-frame.
        send_partial(12'h800, 4);
        #2 rst = 1'b1;
        #1;
        check("midrst_sample", 32'(sample), 32'd0);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(sample_valid), 32'd0);
        send_frame(12'h800, 1'b0, 1'b0);
        check("post_rst_sample", 32'(sample), 32'h800);
        check("post_rst_valid2", 32'(sample_valid), 32'd1);

`ifdef PARITY_CHECK_EN
        consume();
        send_frame(12'h801, 1'b0, 1'b0);
        check("par_ok_sample", 32'(sample), 32'h801);
        check("par_ok_valid", 32'(sample_valid), 32'd1);
        check("par_ok_err", 32'(parity_err), 32'd0);
        consume();
        send_frame(12'h801, 1'b0, 1'b1);
        check("par_bad_err", 32'(parity_err), 32'd1);
        check("par_bad_valid", 32'(sample_valid), 32'd0);
        check("par_bad_overrun", 32'(overrun), 32'd0);
        tick();
        check("par_err_one_cycle", 32'(parity_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
